// File: rtl/psu_pkg.sv
// Shared constants, width helpers and state encoding for the packet start detector.
package psu_pkg;
    localparam int PSU_DW_DEF  = 12;
    localparam int PSU_WIN_DEF = 32;
    localparam int PSU_LAT     = 3;

    function automatic int prod_width(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int acc_width(input int dw, input int win);
        return 2 * dw + 1 + $clog2(win);
    endfunction

    localparam int PROD_W = prod_width(PSU_DW_DEF);
    localparam int ACC_W  = acc_width(PSU_DW_DEF, PSU_WIN_DEF);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BLANK = 2'd2
    } psu_state_t;
endpackage

// File: rtl/psu_corr_win.sv
// Lagged autocorrelation and power over a sliding window: lag line, product stage,
// term ring and running sums. Sums for a sample are valid two cycles after it enters.
module psu_corr_win
    import psu_pkg::*;
#(
    parameter int DW  = 12,
    parameter int LAG = 16,
    parameter int WIN = 32,
    parameter int PW  = PROD_W,
    parameter int AW  = ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 sum_valid,
    output logic signed [AW-1:0] c_re,
    output logic signed [AW-1:0] c_im,
    output logic [AW-1:0]        p_sum
);
    localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;

    logic signed [DW-1:0] lag_re [LAG];
    logic signed [DW-1:0] lag_im [LAG];

    logic signed [PW-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] corr_re_n, corr_im_n, pow_n;

    logic                 term_valid;
    logic signed [PW-1:0] term_re, term_im;
    logic [PW-1:0]        term_p;

    logic signed [PW-1:0] ring_re [WIN];
    logic signed [PW-1:0] ring_im [WIN];
    logic [PW-1:0]        ring_p  [WIN];
    logic [PTR_W-1:0]     wptr;

    always_comb begin
        a_re      = PW'(in_re);
        a_im      = PW'(in_im);
        b_re      = PW'(lag_re[LAG-1]);
        b_im      = PW'(lag_im[LAG-1]);
        corr_re_n = a_re * b_re + a_im * b_im;
        corr_im_n = a_im * b_re - a_re * b_im;
        pow_n     = b_re * b_re + b_im * b_im;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAG; i++) begin
                lag_re[i] <= '0;
                lag_im[i] <= '0;
            end
            term_valid <= 1'b0;
            term_re    <= '0;
            term_im    <= '0;
            term_p     <= '0;
        end else begin
            term_valid <= in_valid;
            if (in_valid) begin
                lag_re[0] <= in_re;
                lag_im[0] <= in_im;
                for (int i = 1; i < LAG; i++) begin
                    lag_re[i] <= lag_re[i-1];
                    lag_im[i] <= lag_im[i-1];
                end
                term_re <= corr_re_n;
                term_im <= corr_im_n;
                term_p  <= $unsigned(pow_n);
            end
        end
    end

    // The ring slot at wptr holds the term leaving the window, so it is subtracted
    // in the same cycle the new term overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) begin
                ring_re[i] <= '0;
                ring_im[i] <= '0;
                ring_p[i]  <= '0;
            end
            wptr      <= '0;
            sum_valid <= 1'b0;
            c_re      <= '0;
            c_im      <= '0;
            p_sum     <= '0;
        end else begin
            sum_valid <= term_valid;
            if (term_valid) begin
                ring_re[wptr] <= term_re;
                ring_im[wptr] <= term_im;
                ring_p[wptr]  <= term_p;
                c_re  <= c_re + AW'(term_re) - AW'(ring_re[wptr]);
                c_im  <= c_im + AW'(term_im) - AW'(ring_im[wptr]);
                p_sum <= p_sum + AW'(term_p) - AW'(ring_p[wptr]);
                wptr  <= (wptr == PTR_W'(WIN - 1)) ? '0 : wptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/psu_detect.sv
// Packet start detector: fixed-latency sample passthrough plus a fill/armed/blank
// FSM that qualifies consecutive autocorrelation threshold hits.
module psu_detect
    import psu_pkg::*;
#(
    parameter int DW      = 12,
    parameter int LAG     = 16,
    parameter int WIN     = 32,
    parameter int THR_NUM = 12,
    parameter int HOLD    = 16,
    parameter int BLANK   = 8000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 di_valid,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic                 det_en,
    output logic                 do_valid,
    output logic signed [DW-1:0] do_re,
    output logic signed [DW-1:0] do_im,
    output logic                 packet_start,
    output logic [7:0]           pkt_cnt,
    output logic                 busy
);
    localparam int PW      = prod_width(DW);
    localparam int AW      = acc_width(DW, WIN);
    localparam int CMP_W   = AW + 6;
    localparam int HIT_W   = $clog2(HOLD + 1);
    localparam int CNT_MAX = (LAG + WIN > BLANK) ? LAG + WIN : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [PSU_LAT-1:0]   pipe_v;
    logic signed [DW-1:0] pipe_re [PSU_LAT];
    logic signed [DW-1:0] pipe_im [PSU_LAT];
    logic [1:0]           en_d;

    logic                 sum_valid;
    logic signed [AW-1:0] c_re, c_im;
    logic [AW-1:0]        p_sum;
    logic [AW-1:0]        mag_re, mag_im;
    logic [CMP_W-1:0]     lhs, rhs;
    logic                 hit;

    psu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [HIT_W-1:0] hit_cnt, hit_cnt_n;
    logic [7:0]       pkt_cnt_n;
    logic             start_n, busy_n;

    psu_corr_win #(.DW(DW), .LAG(LAG), .WIN(WIN), .PW(PW), .AW(AW)) u_corr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (di_valid),
        .in_re     (di_re),
        .in_im     (di_im),
        .sum_valid (sum_valid),
        .c_re      (c_re),
        .c_im      (c_im),
        .p_sum     (p_sum)
    );

    // Data registers only load on valid so the outputs hold through input gaps.
    // det_en travels two stages to meet its own sample at the window sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            en_d   <= '0;
            for (int i = 0; i < PSU_LAT; i++) begin
                pipe_re[i] <= '0;
                pipe_im[i] <= '0;
            end
        end else begin
            pipe_v[0] <= di_valid;
            en_d      <= {en_d[0], det_en};
            if (di_valid) begin
                pipe_re[0] <= di_re;
                pipe_im[0] <= di_im;
            end
            for (int i = 1; i < PSU_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_re[i] <= pipe_re[i-1];
                    pipe_im[i] <= pipe_im[i-1];
                end
            end
        end
    end

    assign do_valid = pipe_v[PSU_LAT-1];
    assign do_re    = pipe_re[PSU_LAT-1];
    assign do_im    = pipe_im[PSU_LAT-1];

    always_comb begin
        mag_re = c_re[AW-1] ? $unsigned(-c_re) : $unsigned(c_re);
        mag_im = c_im[AW-1] ? $unsigned(-c_im) : $unsigned(c_im);
        lhs    = (CMP_W'(mag_re) + CMP_W'(mag_im)) << 4;
        rhs    = CMP_W'(p_sum) * CMP_W'(THR_NUM);
        hit    = (p_sum != '0) && (lhs >= rhs);
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hit_cnt_n = hit_cnt;
        pkt_cnt_n = pkt_cnt;
        start_n   = 1'b0;
        busy_n    = busy;
        if (sum_valid) begin
            case (state)
                ST_FILL: begin
                    if (cnt == CNT_W'(LAG + WIN - 1)) begin
                        state_n = ST_ARMED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!en_d[1] || !hit) begin
                        hit_cnt_n = '0;
                    end else if (hit_cnt == HIT_W'(HOLD - 1)) begin
                        start_n   = 1'b1;
                        pkt_cnt_n = pkt_cnt + 1'b1;
                        hit_cnt_n = '0;
                        cnt_n     = '0;
                        state_n   = ST_BLANK;
                    end else begin
                        hit_cnt_n = hit_cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt == CNT_W'(BLANK - 1)) begin
                        state_n = ST_ARMED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = ST_FILL;
            endcase
            busy_n = (state_n != ST_ARMED);
        end
    end

    // busy is registered so every output reads 0 in reset; it picks up FILL on the
    // first processed sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_FILL;
            cnt          <= '0;
            hit_cnt      <= '0;
            pkt_cnt      <= '0;
            packet_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            hit_cnt      <= hit_cnt_n;
            pkt_cnt      <= pkt_cnt_n;
            packet_start <= start_n;
            busy         <= busy_n;
        end
    end
endmodule

// File: tb/tb_psu_detect.sv
// Directed scenarios plus random traffic for psu_detect, checked cycle by cycle
// against a windowed-sum reference model.
module tb_psu_detect;
    import psu_pkg::*;

    localparam int DW      = 12;
    localparam int LAG     = 16;
    localparam int WIN     = 32;
    localparam int THR_NUM = 12;
    localparam int HOLD    = 16;
    localparam int BLANK   = 8000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 di_valid = 1'b0;
    logic signed [DW-1:0] di_re = '0;
    logic signed [DW-1:0] di_im = '0;
    logic                 det_en = 1'b0;
    logic                 do_valid;
    logic signed [DW-1:0] do_re, do_im;
    logic                 packet_start;
    logic [7:0]           pkt_cnt;
    logic                 busy;

    always #5 clk = ~clk;

    psu_detect #(
        .DW(DW), .LAG(LAG), .WIN(WIN), .THR_NUM(THR_NUM), .HOLD(HOLD), .BLANK(BLANK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .di_valid     (di_valid),
        .di_re        (di_re),
        .di_im        (di_im),
        .det_en       (det_en),
        .do_valid     (do_valid),
        .do_re        (do_re),
        .do_im        (do_im),
        .packet_start (packet_start),
        .pkt_cnt      (pkt_cnt),
        .busy         (busy)
    );

    typedef struct {
        logic                 v;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 ps;
        logic                 bz;
        logic [7:0]           pkt;
        int                   idx;
    } exp_t;

    exp_t exp_q[$];
    int   hist_re[$];
    int   hist_im[$];
    int   blank_left, run_len, pkt_model;
    logic busy_model;
    logic signed [DW-1:0] last_re, last_im;
    int   pulses[$];
    bit   seen_busy;
    int   first_idle_idx;
    int   errors = 0;
    int   checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int tone_val(input int k);
        case (k % 16)
            0: return 500;    1: return 462;    2: return 354;    3: return 191;
            4: return 0;      5: return -191;   6: return -354;   7: return -462;
            8: return -500;   9: return -462;  10: return -354;  11: return -191;
           12: return 0;     13: return 191;   14: return 354;   15: return 462;
            default: return 0;
        endcase
    endfunction

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        exp_t z;
        hist_re.delete();
        hist_im.delete();
        exp_q.delete();
        blank_left = 0;
        run_len    = 0;
        pkt_model  = 0;
        busy_model = 1'b0;
        last_re    = '0;
        last_im    = '0;
        z.v = 1'b0; z.re = '0; z.im = '0; z.ps = 1'b0; z.bz = 1'b0; z.pkt = '0; z.idx = -1;
        repeat (PSU_LAT) exp_q.push_back(z);
    endtask

    // Window sums recomputed from the full sample history of the current run.
    task automatic model_step(input logic v, input logic signed [DW-1:0] re,
                              input logic signed [DW-1:0] im, input logic en, input int idx);
        exp_t   e;
        int     n, lo;
        longint cre, cim, pw, ar, ai, br, bi;
        bit     hit;
        e.ps = 1'b0;
        if (v) begin
            hist_re.push_back(int'(re));
            hist_im.push_back(int'(im));
            n   = hist_re.size() - 1;
            lo  = (n - WIN + 1 > 0) ? n - WIN + 1 : 0;
            cre = 0; cim = 0; pw = 0;
            for (int m = lo; m <= n; m++) begin
                ar = hist_re[m];
                ai = hist_im[m];
                br = (m >= LAG) ? hist_re[m-LAG] : 0;
                bi = (m >= LAG) ? hist_im[m-LAG] : 0;
                cre += ar * br + ai * bi;
                cim += ai * br - ar * bi;
                pw  += br * br + bi * bi;
            end
            hit = (pw != 0) && ((labs(cre) + labs(cim)) * 16 >= pw * THR_NUM);
            if (n >= LAG + WIN) begin
                if (blank_left > 0) begin
                    blank_left--;
                end else if (en && hit) begin
                    run_len++;
                    if (run_len == HOLD) begin
                        e.ps       = 1'b1;
                        pkt_model  = (pkt_model + 1) % 256;
                        run_len    = 0;
                        blank_left = BLANK;
                    end
                end else begin
                    run_len = 0;
                end
            end
            busy_model = (n + 1 < LAG + WIN) || (blank_left > 0);
            last_re = re;
            last_im = im;
        end
        e.v   = v;
        e.re  = last_re;
        e.im  = last_im;
        e.bz  = busy_model;
        e.pkt = pkt_model[7:0];
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        e = exp_q.pop_front();
        check_val("do_valid", do_valid, e.v);
        check_val("do_re", do_re, e.re);
        check_val("do_im", do_im, e.im);
        check_val("packet_start", packet_start, e.ps);
        check_val("busy", busy, e.bz);
        check_val("pkt_cnt", pkt_cnt, e.pkt);
        if (packet_start) pulses.push_back(e.idx);
        if (busy) seen_busy = 1'b1;
        else if (seen_busy && first_idle_idx < 0) first_idle_idx = e.idx;
    endtask

    task automatic apply_stimulus(input logic v, input int re, input int im, input logic en, input int idx);
        @(posedge clk);
        #1;
        di_valid = v;
        di_re    = DW'(re);
        di_im    = DW'(im);
        det_en   = en;
        model_step(v, di_re, di_im, en, idx);
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        di_valid = 1'b0; di_re = '0; di_im = '0; det_en = 1'b0;
        model_reset();
        pulses.delete();
        seen_busy      = 1'b0;
        first_idle_idx = -1;
        @(negedge clk);
        check_val("rst_do_valid", do_valid, 0);
        check_val("rst_do_re", do_re, 0);
        check_val("rst_do_im", do_im, 0);
        check_val("rst_packet_start", packet_start, 0);
        check_val("rst_pkt_cnt", pkt_cnt, 0);
        check_val("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic flush();
        repeat (PSU_LAT + 1) apply_stimulus(1'b0, 0, 0, 1'b1, -1);
    endtask

    function automatic bit in_burst(input int i, input int start);
        return (i >= start) && (i < start + 160);
    endfunction

    initial begin
        int idx;
        bit tone_seg;

        // 1: all-zero input never detects; fill ends after LAG+WIN samples
        do_reset();
        for (int i = 0; i < 2000; i++) apply_stimulus(1'b1, 0, 0, 1'b1, i);
        flush();
        check_val("s1_pulses", pulses.size(), 0);
        check_val("s1_pkt_cnt", pkt_cnt, 0);
        check_val("s1_fill_end", first_idle_idx, 47);

        // 2: one periodic burst
        do_reset();
        for (int i = 0; i < 260; i++) begin
            if (i >= 100) apply_stimulus(1'b1, tone_val(i), tone_val(i + 12), 1'b1, i);
            else          apply_stimulus(1'b1, 0, 0, 1'b1, i);
        end
        flush();
        check_val("s2_pulses", pulses.size(), 1);
        if (pulses.size() > 0) check_val("s2_pulse_idx", pulses[0], 131);
        check_val("s2_pkt_cnt", pkt_cnt, 1);
        check_val("s2_busy_blank", busy, 1);

        // 3: non-periodic noise
        do_reset();
        for (int i = 0; i < 1000; i++)
            apply_stimulus(1'b1, int'($urandom_range(0, 1000)) - 500,
                           int'($urandom_range(0, 1000)) - 500, 1'b1, i);
        flush();
        check_val("s3_pulses", pulses.size(), 0);

        // 4: second burst falls inside blanking, third re-detects
        do_reset();
        for (int i = 0; i < 9200; i++) begin
            if (in_burst(i, 100) || in_burst(i, 3000) || in_burst(i, 9000))
                apply_stimulus(1'b1, tone_val(i), tone_val(i + 12), 1'b1, i);
            else
                apply_stimulus(1'b1, 0, 0, 1'b1, i);
        end
        flush();
        check_val("s4_pulses", pulses.size(), 2);
        if (pulses.size() > 1) begin
            check_val("s4_pulse0_idx", pulses[0], 131);
            check_val("s4_pulse1_idx", pulses[1], 9031);
        end
        check_val("s4_pkt_cnt", pkt_cnt, 2);

        // 5: det_en rises mid-burst
        do_reset();
        for (int i = 0; i < 260; i++) begin
            if (i >= 100) apply_stimulus(1'b1, tone_val(i), tone_val(i + 12), i >= 120, i);
            else          apply_stimulus(1'b1, 0, 0, 1'b0, i);
        end
        flush();
        check_val("s5_pulses", pulses.size(), 1);
        if (pulses.size() > 0) check_val("s5_pulse_idx", pulses[0], 135);

        // 6: gapped input with a reset before sample 125
        do_reset();
        idx = 0;
        while (idx < 260) begin
            if (idx == 125) begin
                do_reset();
                idx = 125;
            end
            if (idx >= 100) apply_stimulus(1'b1, tone_val(idx), tone_val(idx + 12), 1'b1, idx);
            else            apply_stimulus(1'b1, 0, 0, 1'b1, idx);
            apply_stimulus(1'b0, int'($urandom_range(0, 4095)) - 2048,
                           int'($urandom_range(0, 4095)) - 2048, 1'b1, -1);
            idx++;
        end
        flush();
        check_val("s6_pulses", pulses.size(), 1);
        if (pulses.size() > 0) check_val("s6_pulse_idx", pulses[0], 188);
        check_val("s6_pkt_cnt", pkt_cnt, 1);

        // 7: random gaps, det_en dropouts, alternating tone and noise segments
        do_reset();
        idx = 0;
        tone_seg = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) tone_seg = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                if (tone_seg)
                    apply_stimulus(1'b1, tone_val(idx) / 2, tone_val(idx + 12) / 2,
                                   $urandom_range(0, 39) != 0, idx);
                else
                    apply_stimulus(1'b1, int'($urandom_range(0, 1000)) - 500,
                                   int'($urandom_range(0, 1000)) - 500,
                                   $urandom_range(0, 39) != 0, idx);
                idx++;
            end else begin
                apply_stimulus(1'b0, int'($urandom_range(0, 4095)) - 2048,
                               int'($urandom_range(0, 4095)) - 2048, 1'b1, -1);
            end
        end
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psu_detect.md
Name: psu_detect

Overview:
- Parametrised successor to the OFDM receiver's packet start unit (PSU).
- Detects the packet start from short-training periodicity using a delayed autocorrelation: lag LAG, sliding window WIN, ratio threshold, consecutive-hit qualification and post-detection blanking.
- Passes the sample stream through with a fixed 3-cycle latency. packet_start is aligned to the qualifying sample.
- Sits between the TX-out/channel sample source and the CFO/symbol-timing stages.

Parameters:
DW, 12, signed I/Q sample width
LAG, 16, autocorrelation lag in samples (STS period)
WIN, 32, correlation/power window length in samples
THR_NUM, 12, threshold numerator over 16 (12 = 0.75)
HOLD, 16, consecutive hits required to declare a packet
BLANK, 8000, valid samples ignored after a detection before re-arming

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
di_valid  in  1  input sample strobe
di_re  in  DW  input I, two's complement
di_im  in  DW  input Q, two's complement
det_en  in  1  detection enable; when low, data passes and no detection occurs
do_valid  out  1  di_valid delayed 3 cycles
do_re  out  DW  di_re delayed 3 cycles
do_im  out  DW  di_im delayed 3 cycles
packet_start  out  1  one-cycle pulse, coincident with do_valid of the qualifying sample
pkt_cnt  out  8  count of detections, wraps 255 -> 0
busy  out  1  high while in FILL or BLANK

Behaviour:
- Reset (async, rst=1): all outputs 0. Delay lines, accumulators, hit counter and blank counter are 0. State is FILL.
- Latency:
  - do_* and do_valid equal di_* and di_valid exactly 3 clocks earlier, regardless of state or det_en.
  - do_re/do_im hold their last value when do_valid=0.
- Qualification: all internal state advances only on cycles with di_valid=1. Gaps stall the pipeline state but not the passthrough.
- Correlation term per valid sample, with a = x[n] and b = x[n-LAG]:
  - c_re = a_re*b_re + a_im*b_im
  - c_im = a_im*b_re - a_re*b_im
  - 2*DW+1 bit signed.
- Power term: p = b_re^2 + b_im^2, 2*DW+1 bit unsigned.
- Window sums C (complex) and P:
  - Running sums over the last WIN terms: add the newest term, subtract the term WIN samples old (held in a ring).
  - Width 2*DW+1+clog2(WIN). No saturation is needed at these widths.
- Hit when both hold:
  - (|C_re| + |C_im|) * 16 >= P * THR_NUM
  - P != 0 (all-zero input never hits).
- States:
  - FILL: counts LAG+WIN valid samples, then goes to ARMED. No hits are counted.
  - ARMED: hit increments hit_cnt; a non-hit clears it. When hit_cnt reaches HOLD, assert packet_start, increment pkt_cnt, clear hit_cnt, go to BLANK.
  - BLANK: counts BLANK valid samples, then returns to ARMED. Hits are ignored.
- det_en=0:
  - In ARMED, hit_cnt is held at 0 and no pulse occurs.
  - FILL and BLANK counting continue.
  - det_en rising mid-stream starts counting from 0.
- packet_start is registered so it appears on the same cycle as do_valid for the HOLD-th consecutive hit sample.
- Reset mid-packet: immediate return to FILL. Output delay registers are cleared, so do_* read 0 for 3 cycles.
- Simultaneous events:
  - Reaching HOLD on the same sample that det_en falls: det_en sampled with that di_valid wins, so no pulse.
  - pkt_cnt wrap is silent.

Decomposition:
- Package psu_pkg holds:
  - constants ACC_W = 2*DW+1+clog2(WIN) and PROD_W = 2*DW+1
  - state encoding FILL/ARMED/BLANK
  - the latency constant PSU_LAT = 3
- One sub-module, psu_corr_win: the lag delay line, product stage, WIN-deep term ring and running sums. Outputs C_re, C_im, P with their valid.
- The top holds the FSM, counters and passthrough delay.

Test Plan:
- 2000 zero samples with di_valid=1 -> packet_start never asserts; pkt_cnt=0; busy falls after 48 valid samples.
- 100 zeros, then 16-periodic tone of amplitude 500 for 160 samples -> exactly one packet_start, on the cycle do_re equals input index 131; pkt_cnt=1; busy=1 afterwards.
- 1000 samples of LFSR pseudo-random I/Q (non-periodic), amplitude ±500 -> no packet_start.
- Two periodic bursts at indices 100 and 3000 (< BLANK apart), then a third at 9000 -> pulses at 131 and 9031 only; pkt_cnt=2.
- Same as the second scenario with det_en=0 until index 120, then 1 -> pulse at index 135 (hits count from 120).
- Same stimulus with di_valid toggling 1/0, plus rst pulsed at index 125 -> no pulse before reset; after re-fill, detection occurs at the correct valid-sample index; do_valid mirrors di_valid delayed by 3.
